// File: rtl/sys_apb_master.sv
// sys_apb_master: CPU load/store request to APB-style bus master.
// Accepts one request at a time, runs the SETUP/ACCESS phases, builds byte
// strobes and replicated store data, and aligns and extends load data.
// Misaligned requests, slave errors and pready timeouts are reported through
// resp_err.
module sys_apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    // CPU request side
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    // CPU response side
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    // APB side
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [3:0]            pstb,
    input  logic                  pready,
    input  logic                  perr
);

    // The counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit
    // so the design still elaborates when the timeout is disabled.
    localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  unsigned_q;
    logic [3:0]            stb_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [CNT_W-1:0]      cnt;

    logic                  req_misaligned;
    logic [3:0]            req_stb;
    logic [DATA_WIDTH-1:0] req_data;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic [DATA_WIDTH-1:0] rd_ext;
    logic                  timeout_hit;

    // Decode the incoming request into lane strobes, replicated store data
    // and an alignment error flag.
    always_comb begin
        req_misaligned = 1'b0;
        req_stb        = 4'b0000;
        req_data       = '0;
        case (req_size)
            2'd0: begin
                req_stb  = 4'b0001 << req_addr[1:0];
                req_data = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                req_stb        = 4'b0011 << {req_addr[1], 1'b0};
                req_data       = {2{req_wdata[15:0]}};
                req_misaligned = req_addr[0];
            end
            2'd2: begin
                req_stb        = 4'b1111;
                req_data       = req_wdata;
                req_misaligned = |req_addr[1:0];
            end
            default: begin
                req_misaligned = 1'b1;
            end
        endcase
        if (!req_we) begin
            req_data = '0;
        end
    end

    // Right-justify the addressed lane(s) of prdata and extend to full width.
    always_comb begin
        rd_shift = prdata >> {addr_q[1:0], 3'b000};
        rd_ext   = rd_shift;
        case (size_q)
            2'd0: begin
                if (unsigned_q) begin
                    rd_ext = {24'd0, rd_shift[7:0]};
                end else begin
                    rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
                end
            end
            2'd1: begin
                if (unsigned_q) begin
                    rd_ext = {16'd0, rd_shift[15:0]};
                end else begin
                    rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
                end
            end
            default: begin
                rd_ext = rd_shift;
            end
        endcase
    end

    // The ACCESS phase gives up once the counter has seen its last allowed cycle.
    always_comb begin
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TO_LAST));
    end

    // State register; reset drops the bus immediately, mid-transfer or not.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the request / setup / access / response sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = req_misaligned ? RESP : SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (pready || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake and APB control outputs decoded from the current state.
    always_comb begin
        req_ready  = 1'b0;
        psel       = 1'b0;
        penable    = 1'b0;
        pwrite     = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
            end
            SETUP: begin
                psel   = 1'b1;
                pwrite = we_q;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                pwrite  = we_q;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // Request latch, access-phase counter and response capture.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            stb_q      <= 4'b0000;
            data_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr;
                        we_q       <= req_we;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        stb_q      <= req_stb;
                        data_q     <= req_data;
                        rdata_q    <= '0;
                        err_q      <= req_misaligned;
                    end
                end
                SETUP: begin
                    cnt <= '0;
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (pready) begin
                        err_q   <= perr;
                        rdata_q <= (perr || we_q) ? '0 : rd_ext;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    assign paddr      = addr_q;
    assign pdata      = data_q;
    assign pstb       = stb_q;
    assign resp_rdata = rdata_q;

endmodule
